// File: rtl/padc_dig_corr.sv
// Digital correction for a pipelined 1.5-bit/stage ADC: time-aligns the per-stage
// codes, sums them with overlapping weights and flags words containing illegal codes.
module padc_dig_corr #(
    parameter int NSTAGE = 7,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       dig_raw [NSTAGE],
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int FW = $clog2(NSTAGE + 1);

    logic [1:0]       aligned [NSTAGE];
    logic [FW-1:0]    fill_cnt;
    logic [OUT_W-1:0] sum;
    logic [OUT_W-1:0] term;
    logic [1:0]       clamped;
    logic             any_bad;
    logic             word_full;

    // Earlier stages resolve sooner, so they wait longest; the last stage is used directly.
    generate
        for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
            if (i == NSTAGE - 1) begin : g_direct
                assign aligned[i] = dig_raw[i];
            end else begin : g_delay
                localparam int D = NSTAGE - 1 - i;
                logic [1:0] line [D];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < D; k++) line[k] <= 2'b00;
                    end else if (en) begin
                        line[0] <= dig_raw[i];
                        for (int k = 1; k < D; k++) line[k] <= line[k-1];
                    end
                end

                assign aligned[i] = line[D-1];
            end
        end
    endgenerate

    // Illegal code 11 is clamped to 10 so the sum never exceeds 2*(2^NSTAGE-1).
    always_comb begin
        sum     = '0;
        term    = '0;
        clamped = 2'b00;
        any_bad = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            clamped = (aligned[i] == 2'b11) ? 2'b10 : aligned[i];
            term    = {{(OUT_W-2){1'b0}}, clamped};
            sum     = sum + (term << (NSTAGE - 1 - i));
            any_bad = any_bad | (aligned[i] == 2'b11);
        end
    end

    // The word registered on this edge is complete once NSTAGE-1 edges have filled the lines.
    assign word_full = (fill_cnt >= FW'(NSTAGE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
        end else if (en) begin
            if (fill_cnt != FW'(NSTAGE)) fill_cnt <= fill_cnt + FW'(1);
            dout       <= sum;
            dout_valid <= word_full;
            err        <= word_full & any_bad;
            if (word_full && any_bad && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_padc_dig_corr.sv
// Directed bench for padc_dig_corr: table of uniform-code vectors plus
// hand-written skew, error, async-reset and saturation sequences.
module tb_padc_dig_corr;

    localparam int NSTAGE = 7;
    localparam int OUT_W  = 8;

    typedef struct {
        logic       en;
        logic [1:0] code;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       dig_raw [NSTAGE];
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             err;
    logic [7:0]       err_cnt;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [27];

    padc_dig_corr #(.NSTAGE(NSTAGE), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dig_raw    (dig_raw),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic e, input logic [1:0] code);
        en = e;
        for (int i = 0; i < NSTAGE; i++) dig_raw[i] = code;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Uniform-code sequence: fill with 01, ramp to 10, freeze, drain to 00.
        tbl[0]  = '{1'b1, 2'b01, 8'd1,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 8'd3,   1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 8'd7,   1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 8'd15,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b01, 8'd31,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b01, 8'd63,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 8'd127, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'b01, 8'd127, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 8'd128, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'b10, 8'd130, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 8'd134, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 8'd142, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 2'b10, 8'd158, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 2'b10, 8'd190, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 8'd254, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 2'b10, 8'd254, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 8'd254, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 2'b00, 8'd254, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 2'b00, 8'd254, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 2'b00, 8'd252, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 2'b00, 8'd248, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 2'b00, 8'd240, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 2'b00, 8'd224, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 2'b00, 8'd192, 1'b1, 1'b0};
        tbl[24] = '{1'b1, 2'b00, 8'd128, 1'b1, 1'b0};
        tbl[25] = '{1'b1, 2'b00, 8'd0,   1'b1, 1'b0};
        tbl[26] = '{1'b1, 2'b00, 8'd0,   1'b1, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 2'b00);
        #12;
        checkOutput("reset_dout",    int'(dout),       0);
        checkOutput("reset_valid",   int'(dout_valid), 0);
        checkOutput("reset_err",     int'(err),        0);
        checkOutput("reset_err_cnt", int'(err_cnt),    0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 27; n++) begin
            applyStimulus(tbl[n].en, tbl[n].code);
            tick();
            checkOutput($sformatf("tbl%0d_dout", n),  int'(dout),       int'(tbl[n].exp_dout));
            checkOutput($sformatf("tbl%0d_valid", n), int'(dout_valid), int'(tbl[n].exp_valid));
            checkOutput($sformatf("tbl%0d_err", n),   int'(err),        int'(tbl[n].exp_err));
        end

        // Skew: stage k carries 10 only on the k-th edge; they meet in exactly one word.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 2'b00);
            if (k < NSTAGE) dig_raw[k] = 2'b10;
            tick();
            checkOutput($sformatf("skew%0d_dout", k), int'(dout), (k == NSTAGE - 1) ? 254 : 0);
        end

        // Illegal code on stage 3 only, aligned three edges later.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 2'b00);
            if (k == 0) dig_raw[3] = 2'b11;
            tick();
            checkOutput($sformatf("bad%0d_dout", k), int'(dout), (k == 3) ? 16 : 0);
            checkOutput($sformatf("bad%0d_err", k),  int'(err),  (k == 3) ? 1 : 0);
        end
        checkOutput("bad_err_cnt", int'(err_cnt), 1);

        // Asynchronous reset mid-stream, checked before any further clock edge.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'b01);
            tick();
        end
        checkOutput("pre_arst_dout", int'(dout), 7);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_dout",    int'(dout),       0);
        checkOutput("arst_valid",   int'(dout_valid), 0);
        checkOutput("arst_err_cnt", int'(err_cnt),    0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            applyStimulus(1'b1, 2'b01);
            tick();
            checkOutput($sformatf("refill%0d_valid", k), int'(dout_valid), (k == NSTAGE) ? 1 : 0);
        end
        checkOutput("refill_dout", int'(dout), 127);

        // Continuous illegal codes: counter saturates at 255.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            applyStimulus(1'b1, 2'b11);
            tick();
            if (k == 6) begin
                checkOutput("sat6_valid",   int'(dout_valid), 0);
                checkOutput("sat6_err",     int'(err),        0);
                checkOutput("sat6_err_cnt", int'(err_cnt),    0);
                checkOutput("sat6_dout",    int'(dout),       126);
            end
            if (k == 7) begin
                checkOutput("sat7_err",     int'(err),     1);
                checkOutput("sat7_err_cnt", int'(err_cnt), 1);
                checkOutput("sat7_dout",    int'(dout),    254);
            end
            if (k == 260) checkOutput("sat260_err_cnt", int'(err_cnt), 254);
            if (k == 261) checkOutput("sat261_err_cnt", int'(err_cnt), 255);
        end
        checkOutput("sat300_err_cnt", int'(err_cnt), 255);
        checkOutput("sat300_err",     int'(err),     1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
